// File: rtl/hatch_fetch_queue.sv
// Sequential instruction prefetcher: one outstanding fetch on the hatch port, DEPTH-entry queue to decode.
// Optional HATCH_FETCH_STATS_EN adds free-running fetch and flush counters.
module hatch_fetch_queue #(
   parameter int                INSN_W     = 48,
   parameter int                ADDR_W     = 32,
   parameter int                INSN_BYTES = 6,
   parameter int                DEPTH      = 4,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic [ADDR_W-1:0]          hatch_address,
   output logic                       hatch_req,
   input  logic [INSN_W-1:0]          hatch_instruction,
   output logic                       insn_valid,
   input  logic                       insn_ready,
   output logic [INSN_W-1:0]          insn_data,
   output logic [ADDR_W-1:0]          insn_pc,
   input  logic                       redirect_valid,
   input  logic [ADDR_W-1:0]          redirect_pc,
   output logic [$clog2(DEPTH):0]     queue_count
`ifdef HATCH_FETCH_STATS_EN
   ,
   output logic [31:0]                stats_fetches,
   output logic [31:0]                stats_flushes
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [ADDR_W-1:0] r_fetch_pc;
   logic              r_inflight;
   logic [ADDR_W-1:0] r_inflight_pc;
   logic [CNT_W-1:0]  r_count;
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [INSN_W-1:0] r_mem_insn [DEPTH];
   logic [ADDR_W-1:0] r_mem_pc   [DEPTH];

   logic              w_req;
   logic              w_push;
   logic              w_pop;
   logic              w_valid;
   logic [CNT_W:0]    w_occ;

   // Credit counts the outstanding fetch; a same-cycle pop is deliberately not credited.
   assign w_occ   = {1'b0, r_count} + (CNT_W+1)'(r_inflight);
   assign w_req   = !rst && !redirect_valid && (w_occ < (CNT_W+1)'(DEPTH));
   assign w_valid = (r_count != '0);
   assign w_push  = r_inflight && !redirect_valid;
   assign w_pop   = w_valid && insn_ready && !redirect_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_fetch_pc    <= RESET_PC;
         r_inflight    <= 1'b0;
         r_inflight_pc <= '0;
         r_count       <= '0;
         r_head        <= '0;
         r_tail        <= '0;
      end else if (redirect_valid) begin
         r_fetch_pc <= redirect_pc;
         r_inflight <= 1'b0;
         r_count    <= '0;
         r_head     <= '0;
         r_tail     <= '0;
      end else begin
         r_inflight <= w_req;
         if (w_req) begin
            r_inflight_pc <= r_fetch_pc;
            r_fetch_pc    <= r_fetch_pc + ADDR_W'(INSN_BYTES);
         end
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop)  r_head <= r_head + 1'b1;
         r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem_insn[r_tail] <= hatch_instruction;
         r_mem_pc[r_tail]   <= r_inflight_pc;
      end
   end

   // Head fields are forced to zero when empty so reset and flush present clean outputs.
   assign hatch_address = r_fetch_pc;
   assign hatch_req     = w_req;
   assign insn_valid    = w_valid;
   assign insn_data     = w_valid ? r_mem_insn[r_head] : '0;
   assign insn_pc       = w_valid ? r_mem_pc[r_head]   : '0;
   assign queue_count   = r_count;

`ifdef HATCH_FETCH_STATS_EN
   logic [31:0] r_stats_fetches;
   logic [31:0] r_stats_flushes;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stats_fetches <= '0;
         r_stats_flushes <= '0;
      end else begin
         if (w_req)          r_stats_fetches <= r_stats_fetches + 32'd1;
         if (redirect_valid) r_stats_flushes <= r_stats_flushes + 32'd1;
      end
   end

   assign stats_fetches = r_stats_fetches;
   assign stats_flushes = r_stats_flushes;
`endif

   a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
      !(w_push && r_count == CNT_W'(DEPTH)));

endmodule

// File: tb/tb_hatch_fetch_queue.sv
// Directed bench for hatch_fetch_queue: memory model returns address-tagged words one cycle after each request.
module tb_hatch_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] hatch_address;
   logic        hatch_req;
   logic [47:0] hatch_instruction;
   logic        insn_valid;
   logic        insn_ready;
   logic [47:0] insn_data;
   logic [31:0] insn_pc;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [2:0]  queue_count;
`ifdef HATCH_FETCH_STATS_EN
   logic [31:0] stats_fetches;
   logic [31:0] stats_flushes;
`endif

   int n_checks = 0;
   int n_errors = 0;

   hatch_fetch_queue dut (
      .clk               (clk),
      .rst               (rst),
      .hatch_address     (hatch_address),
      .hatch_req         (hatch_req),
      .hatch_instruction (hatch_instruction),
      .insn_valid        (insn_valid),
      .insn_ready        (insn_ready),
      .insn_data         (insn_data),
      .insn_pc           (insn_pc),
      .redirect_valid    (redirect_valid),
      .redirect_pc       (redirect_pc),
      .queue_count       (queue_count)
`ifdef HATCH_FETCH_STATS_EN
      ,
      .stats_fetches     (stats_fetches),
      .stats_flushes     (stats_flushes)
`endif
   );

   always #5 clk = ~clk;

   // Data is only meaningful the cycle after a request; otherwise a poison word.
   always @(posedge clk) begin
      if (hatch_req) hatch_instruction <= {16'hC0DE, hatch_address};
      else           hatch_instruction <= 48'hBAD0_BAD0_BAD0;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end else begin
         $display("ok   %s = %0h", tag, got);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, ".hatch_req"},   64'(hatch_req),     64'h0);
      check_val({tag, ".insn_valid"},  64'(insn_valid),    64'h0);
      check_val({tag, ".queue_count"}, 64'(queue_count),   64'h0);
      check_val({tag, ".hatch_addr"},  64'(hatch_address), 64'h0);
      check_val({tag, ".insn_data"},   64'(insn_data),     64'h0);
      check_val({tag, ".insn_pc"},     64'(insn_pc),       64'h0);
   endtask

   initial begin
      rst               = 1'b1;
      insn_ready        = 1'b0;
      redirect_valid    = 1'b0;
      redirect_pc       = 32'h0;
      hatch_instruction = 48'h0;

      // Fill from reset with decode stalled.
      repeat (2) @(posedge clk);
      #3;
      check_reset_outputs("rst");
      rst = 1'b0;
      #1;
      for (int i = 0; i < 4; i++) begin
         check_val($sformatf("fill.req%0d", i),  64'(hatch_req),     64'h1);
         check_val($sformatf("fill.addr%0d", i), 64'(hatch_address), 64'(i * 6));
         if (i == 2) begin
            check_val("fill.first_valid", 64'(insn_valid), 64'h1);
            check_val("fill.first_pc",    64'(insn_pc),    64'h0);
         end
         cyc(); #1;
      end
      check_val("fill.c4_req",   64'(hatch_req),   64'h0);
      check_val("fill.c4_count", 64'(queue_count), 64'h3);
      cyc(); #1;
      check_val("fill.full_count", 64'(queue_count), 64'h4);
      check_val("fill.full_req",   64'(hatch_req),   64'h0);
      check_val("fill.head_data",  64'(insn_data),   64'h0000_C0DE_0000_0000);
      cyc(); #1;
      check_val("fill.hold_pc",    64'(insn_pc),     64'h0);
      check_val("fill.hold_count", 64'(queue_count), 64'h4);
`ifdef HATCH_FETCH_STATS_EN
      check_val("stats.fetches", 64'(stats_fetches), 64'h4);
      check_val("stats.flushes0", 64'(stats_flushes), 64'h0);
`endif

      // Redirect with a pop offered in the same cycle on a full queue.
      insn_ready     = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h2000;
      #1;
      check_val("rdfull.req", 64'(hatch_req), 64'h0);
      cyc();
      redirect_valid = 1'b0;
      insn_ready     = 1'b0;
      #1;
      check_val("rdfull.count", 64'(queue_count),   64'h0);
      check_val("rdfull.valid", 64'(insn_valid),    64'h0);
      check_val("rdfull.addr",  64'(hatch_address), 64'h2000);
`ifdef HATCH_FETCH_STATS_EN
      check_val("stats.flushes1", 64'(stats_flushes), 64'h1);
`endif
      cyc(); cyc(); #1;
      check_val("rdfull.pc", 64'(insn_pc), 64'h2000);
      cyc(); cyc(); #1;
      check_val("rd3.count_before", 64'(queue_count), 64'h3);
      check_val("rd3.req_before",   64'(hatch_req),   64'h0);

      // Redirect with three queued and one in flight.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1001;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check_val("rd3.count", 64'(queue_count),   64'h0);
      check_val("rd3.addr0", 64'(hatch_address), 64'h1001);
      check_val("rd3.req0",  64'(hatch_req),     64'h1);
      cyc(); #1;
      check_val("rd3.addr1", 64'(hatch_address), 64'h1007);
      check_val("rd3.drop",  64'(queue_count),   64'h0);
      cyc(); #1;
      check_val("rd3.valid", 64'(insn_valid), 64'h1);
      check_val("rd3.pc",    64'(insn_pc),    64'h1001);
      check_val("rd3.data",  64'(insn_data),  64'h0000_C0DE_0000_1001);

      // Address wraparound.
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      insn_ready     = 1'b1;
      cyc();
      redirect_valid = 1'b0;
      #1;
      check_val("wrap.addr0", 64'(hatch_address), 64'hFFFF_FFFC);
      cyc(); #1;
      check_val("wrap.addr1", 64'(hatch_address), 64'h0000_0002);
      cyc(); #1;
      check_val("wrap.pc0", 64'(insn_pc), 64'hFFFF_FFFC);
      cyc(); #1;
      check_val("wrap.pc1",   64'(insn_pc),   64'h0000_0002);
      check_val("wrap.data1", 64'(insn_data), 64'h0000_C0DE_0000_0002);

      // Reset while one fetch is in flight and two entries queued.
      redirect_valid = 1'b1;
      redirect_pc    = 32'h3000;
      insn_ready     = 1'b0;
      cyc();
      redirect_valid = 1'b0;
      cyc(); cyc(); cyc(); #1;
      check_val("mrst.count_before", 64'(queue_count), 64'h2);
      rst = 1'b1;
      #1;
      check_reset_outputs("mrst");
      cyc();
      rst        = 1'b0;
      insn_ready = 1'b1;
      #1;
      check_val("mrst.addr", 64'(hatch_address), 64'h0);
      check_val("mrst.req",  64'(hatch_req),     64'h1);
      cyc(); #1;
      check_val("mrst.stale", 64'(queue_count), 64'h0);

      // Streaming with decode always ready.
      for (int i = 0; i < 5; i++) begin
         cyc(); #1;
         check_val($sformatf("stream.valid%0d", i), 64'(insn_valid), 64'h1);
         check_val($sformatf("stream.pc%0d", i),    64'(insn_pc),    64'(i * 6));
         check_val($sformatf("stream.cnt%0d", i),   64'(queue_count <= 3'd2), 64'h1);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
